// File: rtl/shared_mem_responder_if.sv
// FPGA request/response port of the shared-memory responder.
// master = compute block (initiator), slave = responder.
interface shared_mem_responder_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              rd_req;
    logic              FPGA_wr_en;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] write_data;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_req, FPGA_wr_en, req_addr, write_data,
        input  rd_ready, rd_data
    );

    modport slave (
        input  rd_req, FPGA_wr_en, req_addr, write_data,
        output rd_ready, rd_data
    );
endinterface

// File: rtl/shared_mem_responder.sv
// Shared-memory responder: queues FPGA requests, arbitrates them against
// host PCI writes onto one SRAM port, returns read data with rd_ready.
// Ports: clk, rst_n (sync, active low); fpga (request/response bus);
// pci_wr_en/pci_req_addr/pci_input_data (host writes); flag_we/out_flag/
// in_flag (handshake flag register); sram_* (registered SRAM port plus
// sram_rdata); ovf_err (sticky overflow / protocol error).
module shared_mem_responder #(
    parameter int              ADDR_W     = 21,
    parameter int              DATA_W     = 32,
    parameter int              RD_LAT     = 1,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] FLAG_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_mem_responder_if.slave fpga,
    input  logic                 pci_wr_en,
    input  logic [ADDR_W-1:0]    pci_req_addr,
    input  logic [DATA_W-1:0]    pci_input_data,
    input  logic                 flag_we,
    input  logic [31:0]          out_flag,
    output logic [31:0]          in_flag,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    sram_wdata,
    output logic                 sram_we,
    output logic                 sram_re,
    input  logic [DATA_W-1:0]    sram_rdata,
    output logic                 ovf_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [RD_LAT:0]   rd_vld;

    req_t in_req;
    req_t head;
    logic push;
    logic pop;
    logic accept;
    logic full;
    logic empty;
    logic pci_flag;
    logic pci_sram;
    logic proto_err;
    logic issue_rd;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // A simultaneous read is dropped; only the write survives.
        in_req.is_wr = fpga.FPGA_wr_en;
        in_req.addr  = fpga.req_addr;
        in_req.data  = fpga.write_data;
        push      = fpga.FPGA_wr_en | fpga.rd_req;
        proto_err = fpga.FPGA_wr_en & fpga.rd_req;
        pci_flag  = pci_wr_en && (pci_req_addr == FLAG_ADDR);
        pci_sram  = pci_wr_en && !pci_flag;
        empty     = (count == '0);
        full      = (count == CNT_W'(FIFO_DEPTH));
        // An empty queue lets the arriving request issue at the same edge
        // it is captured; it still reaches SRAM only through the registers.
        pop       = !pci_sram && (!empty || push);
        accept    = push && (!full || pop);
        head      = empty ? in_req : fifo_mem[rd_ptr];
        issue_rd  = pop && !head.is_wr;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= in_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            sram_re    <= 1'b0;
        end else if (pci_sram) begin
            sram_addr  <= pci_req_addr;
            sram_wdata <= pci_input_data;
            sram_we    <= 1'b1;
            sram_re    <= 1'b0;
        end else if (pop) begin
            sram_addr  <= head.addr;
            sram_wdata <= head.data;
            sram_we    <= head.is_wr;
            sram_re    <= !head.is_wr;
        end else begin
            sram_we    <= 1'b0;
            sram_re    <= 1'b0;
        end
    end

    // Stage k is set k cycles after sram_re; stage RD_LAT marks valid rdata.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld        <= '0;
            fpga.rd_ready <= 1'b0;
            fpga.rd_data  <= '0;
        end else begin
            rd_vld        <= {rd_vld[RD_LAT-1:0], issue_rd};
            fpga.rd_ready <= rd_vld[RD_LAT];
            if (rd_vld[RD_LAT]) begin
                fpga.rd_data <= sram_rdata;
            end
        end
    end

    // Host wins a same-cycle flag collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_flag <= '0;
        end else if (pci_flag) begin
            in_flag <= 32'(pci_input_data);
        end else if (flag_we) begin
            in_flag <= out_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (proto_err || (push && !accept)) begin
            ovf_err <= 1'b1;
        end
    end

endmodule
